// File: rtl/seg7_reader_pkg.sv
// Shared constants for the two-digit 7-segment display bus: segment codes, FSM states, payload type.
package seg7_reader_pkg;

    localparam int unsigned SEG_W    = 7;
    localparam int unsigned NIB_W    = 4;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned DIGITS   = 2;
    localparam int unsigned PAIR_W   = SEG_W * DIGITS;

    // Active-low segment codes {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_HOLD   = 1'b1
    } state_t;

    typedef struct packed {
        logic [SEG_W-1:0] seg1;
        logic [SEG_W-1:0] seg0;
    } seg_pair_t;

    // Hex encoder shared with the display driver
    function automatic logic [SEG_W-1:0] seg7_encode(input logic [NIB_W-1:0] nib);
        logic [SEG_W-1:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_reader_if.sv
// Display read-back bus: segment lines in, decoded byte and status pulses out.
interface seg7_reader_if;
    import seg7_reader_pkg::*;

    logic [SEG_W-1:0]  seg0_i;
    logic [SEG_W-1:0]  seg1_i;
    logic [BYTE_W-1:0] data_o;
    logic              valid_o;
    logic              invalid_o;
    logic [BYTE_W-1:0] err_cnt_o;

    modport master (
        output seg0_i, seg1_i,
        input  data_o, valid_o, invalid_o, err_cnt_o
    );

    modport slave (
        input  seg0_i, seg1_i,
        output data_o, valid_o, invalid_o, err_cnt_o
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational single-digit decoder: active-low segment pattern to nibble, with legal/blank flags.
module seg7_decode
    import seg7_reader_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic [NIB_W-1:0] nibble,
    output logic             legal,
    output logic             blank
);

    always_comb begin
        nibble = '0;
        legal  = 1'b1;
        blank  = (pattern == SEG_BLANK);
        case (pattern)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Display read-back: synchronise segment lines, wait for a stable pattern, decode and report once.
module seg7_reader
    import seg7_reader_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 5
) (
    input  logic          clk_50m,
    input  logic          rst_n_i,
    seg7_reader_if.slave  bus
);

    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [BYTE_W-1:0] ERR_MAX = '1;

    seg_pair_t         raw_c;
    seg_pair_t         sync1_q;
    seg_pair_t         sync2_q;
    seg_pair_t         s_q;
    logic [CNT_W-1:0]  cnt_q;
    state_t            state_q;
    logic [BYTE_W-1:0] data_q;
    logic              valid_q;
    logic              invalid_q;
    logic [BYTE_W-1:0] err_q;

    logic [NIB_W-1:0]  nib0_c;
    logic [NIB_W-1:0]  nib1_c;
    logic              legal0_c;
    logic              legal1_c;
    logic              blank0_c;
    logic              blank1_c;
    logic              same_c;
    logic              ready_c;

    assign raw_c.seg1 = bus.seg1_i;
    assign raw_c.seg0 = bus.seg0_i;

    assign same_c  = (sync2_q == s_q);
    assign ready_c = same_c && (cnt_q == CNT_MAX);

    seg7_decode u_dec0 (
        .pattern (sync2_q.seg0),
        .nibble  (nib0_c),
        .legal   (legal0_c),
        .blank   (blank0_c)
    );

    seg7_decode u_dec1 (
        .pattern (sync2_q.seg1),
        .nibble  (nib1_c),
        .legal   (legal1_c),
        .blank   (blank1_c)
    );

    // Two-flop synchroniser, snapshot and saturating stability counter; reset to the blank pattern
    always_ff @(posedge clk_50m or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= '1;
            sync2_q <= '1;
            s_q     <= '1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
            s_q     <= sync2_q;
            if (!same_c) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Report FSM: one evaluation per stable window, then wait in HOLD for the next change
    always_ff @(posedge clk_50m or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_SETTLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
            err_q     <= '0;
        end else begin
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
            case (state_q)
                ST_SETTLE: begin
                    if (ready_c) begin
                        state_q <= ST_HOLD;
                        if (legal1_c && legal0_c) begin
                            data_q  <= {nib1_c, nib0_c};
                            valid_q <= 1'b1;
                        end else if (!(blank1_c && blank0_c)) begin
                            invalid_q <= 1'b1;
                            if (err_q != ERR_MAX) begin
                                err_q <= err_q + BYTE_W'(1);
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (!same_c) begin
                        state_q <= ST_SETTLE;
                    end
                end
                default: state_q <= ST_SETTLE;
            endcase
        end
    end

    assign bus.data_o    = data_q;
    assign bus.valid_o   = valid_q;
    assign bus.invalid_o = invalid_q;
    assign bus.err_cnt_o = err_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: run-length reference model feeds a queue, a monitor checks pulses.
module tb_seg7_reader;
    import seg7_reader_pkg::*;

    localparam int STABLE = 4;

    typedef struct {
        bit          is_valid;
        logic [7:0]  data;
        logic [7:0]  err;
        int          due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    seg7_reader_if bus();

    seg7_reader #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
        .clk_50m (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    // Reference decode table, written out independently of the design package
    logic [6:0] tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [13:0] last;
    int          run_len;
    logic [7:0]  m_data;
    logic [7:0]  m_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -1 illegal, 16 blank, else the digit value
    function automatic int nib(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (tbl[i] == p) return i;
        end
        if (p == 7'h7F) return 16;
        return -1;
    endfunction

    task automatic expect_report(input logic [6:0] s1, input logic [6:0] s0);
        int   h;
        int   l;
        exp_t e;
        h     = nib(s1);
        l     = nib(s0);
        e.due = cyc + 3;
        if (h >= 0 && h < 16 && l >= 0 && l < 16) begin
            m_data     = {4'(h), 4'(l)};
            e.is_valid = 1'b1;
        end else if (h == 16 && l == 16) begin
            return;
        end else begin
            e.is_valid = 1'b0;
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
        e.data = m_data;
        e.err  = m_err;
        q.push_back(e);
    endtask

    // Called at a falling edge: drive inputs for the next rising edge, then advance one cycle.
    // A report is due once the same input has been sampled on STABLE+1 consecutive edges.
    task automatic step(input logic [6:0] s1, input logic [6:0] s0);
        bus.seg1_i = s1;
        bus.seg0_i = s0;
        if ({s1, s0} != last) begin
            last    = {s1, s0};
            run_len = 1;
        end else begin
            run_len++;
        end
        if (run_len == STABLE + 1) expect_report(s1, s0);
        @(negedge clk);
    endtask

    task automatic hold(input logic [6:0] s1, input logic [6:0] s0, input int n);
        repeat (n) step(s1, s0);
    endtask

    function automatic logic [6:0] rnd_digit();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 60) return tbl[$urandom_range(0, 15)];
        if (r < 75) return 7'h7F;
        return 7'($urandom);
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.valid_o || bus.invalid_o) begin
                chk("pulse_exclusive", 32'(bus.valid_o & bus.invalid_o), 32'd0);
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: valid=%b invalid=%b data=%h, expected no pulse (cycle %0d)",
                             bus.valid_o, bus.invalid_o, bus.data_o, cyc);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind_valid", 32'(bus.valid_o), 32'(e.is_valid));
                    chk("data", 32'(bus.data_o), 32'(e.data));
                    chk("err_cnt", 32'(bus.err_cnt_o), 32'(e.err));
                    chk("latency_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (q.size() > 0 && q[0].due < cyc) begin
                e = q.pop_front();
                tests++;
                fails++;
                $display("FAIL missing_pulse: no pulse observed, expected %s data=%h at cycle %0d (now %0d)",
                         e.is_valid ? "valid" : "invalid", e.data, e.due, cyc);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] r1;
        logic [6:0] r0;
        logic [7:0] v;
        bus.seg0_i = 7'h7F;
        bus.seg1_i = 7'h7F;
        last       = '1;
        run_len    = 0;
        m_data     = '0;
        m_err      = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk("reset_data", 32'(bus.data_o), 32'h0);
        chk("reset_valid", 32'(bus.valid_o), 32'h0);
        rst_n = 1'b1;

        // Blank display: nothing to report
        hold(7'h7F, 7'h7F, 50);
        chk("blank_data", 32'(bus.data_o), 32'h00);
        chk("blank_err", 32'(bus.err_cnt_o), 32'h00);

        // 2F held; latency checked by the monitor
        hold(tbl[2], tbl[15], 40);
        chk("hold_2f", 32'(bus.data_o), 32'h2F);

        // Short glitch to 21 and a short return to 2F, then 21 held
        hold(tbl[2], tbl[1], 3);
        hold(tbl[2], tbl[15], 2);
        hold(tbl[2], tbl[1], 20);
        chk("hold_21", 32'(bus.data_o), 32'h21);

        // One blank digit, then an illegal code
        hold(tbl[2], 7'h7F, 20);
        chk("half_blank_err", 32'(bus.err_cnt_o), 32'd1);
        chk("half_blank_data", 32'(bus.data_o), 32'h21);
        hold(tbl[2], 7'b0101010, 20);
        chk("illegal_err", 32'(bus.err_cnt_o), 32'd2);

        // Random patterns with random hold lengths, including glitches
        repeat (150) begin
            r1 = rnd_digit();
            r0 = rnd_digit();
            hold(r1, r0, int'($urandom_range(1, 10)));
        end
        hold(7'h7F, 7'h7F, 20);
        chk("random_err", 32'(bus.err_cnt_o), 32'(m_err));
        chk("random_data", 32'(bus.data_o), 32'(m_data));

        // Error counter saturation
        repeat (150) begin
            hold(7'b0101010, 7'b0101010, 10);
            hold(7'b1010101, 7'b0110110, 10);
        end
        chk("err_saturate", 32'(bus.err_cnt_o), 32'hFF);

        // Reset during the stability window of a valid pattern
        hold(tbl[5], tbl[10], 4);
        rst_n   = 1'b0;
        last    = '1;
        run_len = 0;
        m_data  = '0;
        m_err   = '0;
        chk("pending_at_reset", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_data", 32'(bus.data_o), 32'h00);
        chk("rst_err", 32'(bus.err_cnt_o), 32'h00);
        chk("rst_valid", 32'(bus.valid_o), 32'h0);
        chk("rst_invalid", 32'(bus.invalid_o), 32'h0);
        rst_n = 1'b1;
        hold(tbl[5], tbl[10], 20);
        chk("after_reset_data", 32'(bus.data_o), 32'h5A);

        // Round trip through the shared encoder
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            hold(seg7_encode(v[7:4]), seg7_encode(v[3:0]), 10);
        end
        hold(7'h7F, 7'h7F, 20);
        chk("roundtrip_err", 32'(bus.err_cnt_o), 32'h00);
        chk("roundtrip_last", 32'(bus.data_o), 32'hFF);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
